prog_loader: RTL and testbench

- Host-side initiator for the stack CPU's start/halt run handshake.
- Accepts a byte stream of 9-bit instructions and writes them into the instruction RAM.
- Then drives `start` to the CPU, waits for `halt`, and reports the run's cycle count, or a timeout.
- Sits between the test/host link and the CPU top level plus its instruction memory write port.

---
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Loads a byte stream of 9-bit instructions into instruction RAM, then runs the CPU via start/halt.
// Latency: RAM write 1 cycle after high-byte handshake; start follows the last write by 1 cycle.
// Backpressure: in_ready is high only in the load states; a stalled stream waits with no timeout.
module prog_loader #(
    parameter int ADDR_W       = 9,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] go_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [8:0]        im_wdata,
    output logic              start,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [15:0]       cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_LO,
        S_LOAD_HI,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0]  SCNT_FULL = 8'(START_CYCLES);
    localparam logic [7:0]  SCNT_GO   = 8'(START_CYCLES - 1);
    localparam logic [16:0] TO_LIMIT  = 17'(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        lo_q, lo_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [8:0]        im_wdata_q, im_wdata_d;
    logic              start_q, start_d;
    logic [7:0]        scnt_q, scnt_d;
    logic [15:0]       cycles_q, cycles_d;
    logic              timed_out_q, timed_out_d;

    logic [ADDR_W-1:0] addr_inc;
    logic [16:0]       cycles_inc;
    logic              unused_hi_bits;

    assign addr_inc       = addr_q + ADDR_W'(1);
    assign cycles_inc     = {1'b0, cycles_q} + 17'd1;
    assign unused_hi_bits = ^in_data[7:1];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        im_we_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        start_d     = 1'b0;
        scnt_d      = scnt_q;
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    len_d       = go_len;
                    addr_d      = '0;
                    timed_out_d = 1'b0;
                    if (go_len != '0) begin
                        state_d = S_LOAD_LO;
                    end else begin
                        // Nothing to write: start is raised on the very next cycle.
                        state_d  = S_START;
                        start_d  = 1'b1;
                        scnt_d   = SCNT_GO;
                        cycles_d = '0;
                    end
                end
            end
            S_LOAD_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lo_d    = in_data;
                    state_d = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = addr_q;
                    im_wdata_d = {in_data[0], lo_q};
                    addr_d     = addr_inc;
                    if (addr_inc == len_q) begin
                        // First START cycle overlaps the write strobe, so start stays low for it.
                        state_d  = S_START;
                        scnt_d   = SCNT_FULL;
                        cycles_d = '0;
                    end else begin
                        state_d = S_LOAD_LO;
                    end
                end
            end
            S_START: begin
                if (scnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    scnt_d  = scnt_q - 8'd1;
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_DONE;
                end else begin
                    if (cycles_q != 16'hFFFF) begin
                        cycles_d = cycles_inc[15:0];
                    end
                    if (cycles_inc >= TO_LIMIT) begin
                        timed_out_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            start_q     <= 1'b0;
            scnt_q      <= '0;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            start_q     <= start_d;
            scnt_q      <= scnt_d;
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign start     = start_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign timed_out = timed_out_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load/run records plus hand-written reset-mid-load sequence.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [8:0]  go_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        im_we;
    logic [8:0]  im_addr;
    logic [8:0]  im_wdata;
    logic        start;
    logic        halt = 1'b0;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [15:0] cycles;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(9), .START_CYCLES(2), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .go_len(go_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .start(start), .halt(halt), .busy(busy), .done(done),
        .timed_out(timed_out), .cycles(cycles)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    typedef struct {
        int             len;
        logic [3:0][8:0] w;
        int             max_gap;
        int             halt_after;     // -1: never halt
        int             halt_in_start;
        int             poke;
        int             exp_cycles;
        int             exp_to;
    } vec_t;

    typedef struct { logic [8:0] a; logic [8:0] d; } wr_t;
    typedef struct { int c; int to; } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  mon_w;
    res_t mon_r;
    logic prev_we = 1'b0;

    // Scoreboard side: pop expected writes and run results as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (im_we) begin
                check("im_we_single_cycle", int'(prev_we), 0);
                if (wq.size() == 0) begin
                    check("unexpected_write", int'(im_we), 0);
                end else begin
                    mon_w = wq.pop_front();
                    check("im_addr", int'(im_addr), int'(mon_w.a));
                    check("im_wdata", int'(im_wdata), int'(mon_w.d));
                end
            end
            if (done) begin
                if (rq.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    mon_r = rq.pop_front();
                    check("cycles", int'(cycles), mon_r.c);
                    check("timed_out", int'(timed_out), mon_r.to);
                end
            end
        end
        prev_we = im_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int k = 0; k < g; k++) begin
            @(negedge clk);
            check("in_ready_stall", int'(in_ready), 1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        check("in_ready_load", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] w, input int max_gap, input int poke_go);
        logic [7:0] hb;
        hb    = 8'($urandom);
        hb[0] = w[8];
        send_byte(w[7:0], max_gap);
        if (poke_go != 0) begin
            go     = 1'b1;
            go_len = 9'd7;
        end
        send_byte(hb, max_gap);
        go     = 1'b0;
        go_len = '0;
    endtask

    task automatic do_run(input vec_t v);
        int pre;
        int got;
        for (int i = 0; i < v.len; i++) wq.push_back('{a: 9'(i), d: v.w[i]});
        rq.push_back('{c: v.exp_cycles, to: v.exp_to});
        go     = 1'b1;
        go_len = 9'(v.len);
        tick();
        go     = 1'b0;
        go_len = '0;
        #1;
        check("busy_after_go", int'(busy), 1);
        check("timed_out_cleared_by_go", int'(timed_out), 0);
        for (int i = 0; i < v.len; i++) send_word(v.w[i], v.max_gap, (v.poke != 0 && i == 0) ? 1 : 0);
        pre = (v.len != 0) ? 1 : 0;
        if (v.halt_in_start != 0) halt = 1'b1;
        for (int k = 0; k < pre + 2; k++) begin
            @(negedge clk);
            check("start_seq", int'(start), (k >= pre) ? 1 : 0);
            tick();
        end
        halt = 1'b0;
        if (v.halt_after >= 0) begin
            for (int k = 0; k < v.halt_after; k++) begin
                if (v.poke != 0 && k == 0) begin
                    go       = 1'b1;
                    go_len   = '0;
                    in_valid = 1'b1;
                end
                @(negedge clk);
                if (k == 0) check("start_low_in_run", int'(start), 0);
                if (v.poke != 0 && k == 0) check("in_ready_in_run", int'(in_ready), 0);
                tick();
                go       = 1'b0;
                in_valid = 1'b0;
            end
            halt = 1'b1;
            tick();
            halt = 1'b0;
        end
        got = 0;
        for (int t = 0; t < 100 && got == 0; t++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        tick();
        @(negedge clk);
        check("busy_idle", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("cycles_hold", int'(cycles), v.exp_cycles);
        tick();
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        vecs[0] = '{3, {9'h000, 9'h0FF, 9'h034, 9'h112}, 0, 10, 0, 0, 10, 0};
        vecs[1] = '{0, {9'h000, 9'h000, 9'h000, 9'h000}, 0, 1, 0, 0, 1, 0};
        vecs[2] = '{2, {9'h000, 9'h000, 9'h1A5, 9'h05A}, 0, -1, 0, 0, 20, 1};
        vecs[3] = '{0, {9'h000, 9'h000, 9'h000, 9'h000}, 0, 5, 1, 0, 5, 0};
        vecs[4] = '{1, {9'h000, 9'h000, 9'h000, 9'h1FF}, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{0, {9'h000, 9'h000, 9'h000, 9'h000}, 0, 19, 0, 0, 19, 0};
        vecs[6] = '{4, {9'h100, 9'h0FF, 9'h034, 9'h112}, 5, 3, 0, 0, 3, 0};
        vecs[7] = '{2, {9'h000, 9'h000, 9'h0C3, 9'h13C}, 0, 4, 0, 1, 4, 0};

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(start), 0);
        check("rst_im_we", int'(im_we), 0);
        check("rst_im_addr", int'(im_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_timed_out", int'(timed_out), 0);
        check("rst_cycles", int'(cycles), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) do_run(vecs[i]);

        // Reset in the cycle of the second write strobe.
        wq.push_back('{a: 9'd0, d: 9'h155});
        wq.push_back('{a: 9'd1, d: 9'h0AA});
        go     = 1'b1;
        go_len = 9'd3;
        tick();
        go     = 1'b0;
        go_len = '0;
        send_word(9'h155, 0, 0);
        send_word(9'h0AA, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_im_we", int'(im_we), 0);
        check("midrst_start", int'(start), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_im_addr", int'(im_addr), 0);
        check("midrst_wq_drained", wq.size(), 0);
        #1 rst_n = 1'b1;
        tick();
        rv = '{1, {9'h000, 9'h000, 9'h000, 9'h1C3}, 0, 2, 0, 0, 2, 0};
        do_run(rv);

        check("final_write_queue_empty", wq.size(), 0);
        check("final_result_queue_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
